// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and a lookup helper.
package seg7_pkg;

  // Bit positions inside the 8-bit segment byte {a,b,c,d,e,f,g,dp}.
  localparam int unsigned SEG_A  = 7;
  localparam int unsigned SEG_B  = 6;
  localparam int unsigned SEG_C  = 5;
  localparam int unsigned SEG_D  = 4;
  localparam int unsigned SEG_E  = 3;
  localparam int unsigned SEG_F  = 2;
  localparam int unsigned SEG_G  = 1;
  localparam int unsigned SEG_DP = 0;

  // Active-high glyphs for 0..F; bit 0 (dp) is always clear here.
  localparam logic [7:0] GLYPH_TABLE [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  // Returns the seven segments {a..g} lit for a hex nibble.
  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble][SEG_A:SEG_G];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to {a..g} segment decoder (active-high).
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Table lookup of the glyph for the selected nibble.
  always_comb begin
    segs = glyph(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with atomic shadow update,
// per-slot anode guard interval and selectable pin polarity.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned SLOT_HZ        = 1000,
  parameter int unsigned GUARD          = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        load,
  input  logic [4*N_DIGITS-1:0]                       digits,
  input  logic [N_DIGITS-1:0]                         dp,
  input  logic [N_DIGITS-1:0]                         blank,
  output logic [7:0]                                  seg,
  output logic [N_DIGITS-1:0]                         an,
  output logic [((N_DIGITS > 1) ? $clog2(N_DIGITS) : 1)-1:0] scan_idx
);

  localparam int unsigned DIV = CLK_HZ / SLOT_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  generate
    if (DIV < 2) begin : g_bad_div
      $error("seg7_scan_driver: CLK_HZ/SLOT_HZ must be at least 2");
    end
    if (GUARD >= DIV) begin : g_bad_guard
      $error("seg7_scan_driver: GUARD must be less than CLK_HZ/SLOT_HZ");
    end
    if (N_DIGITS < 1 || N_DIGITS > 8) begin : g_bad_ndig
      $error("seg7_scan_driver: N_DIGITS must be in 1..8");
    end
  endgenerate

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  tick;
  logic [4*N_DIGITS-1:0] sh_digits;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blank;
  logic [3:0]            nib;
  logic                  dp_bit;
  logic                  blank_bit;
  logic [6:0]            glyph7;
  logic [N_DIGITS-1:0]   an_nx;
  logic [7:0]            seg_nx;
  logic [N_DIGITS-1:0]   an_r;
  logic [7:0]            seg_r;

  // End-of-slot strobe from the prescaler.
  always_comb begin
    tick = (cnt == CW'(DIV - 1));
  end

  // Prescaler and scan index; a single-digit build keeps idx at 0 since 0 is also the last index.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow register: all three fields captured together so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_digits <= '0;
      sh_dp     <= '0;
      sh_blank  <= '1;
    end else if (load) begin
      sh_digits <= digits;
      sh_dp     <= dp;
      sh_blank  <= blank;
    end
  end

  // Select the current digit's fields and build the one-hot anode with the guard gap.
  always_comb begin
    nib       = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    an_nx     = '0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib       = sh_digits[4*k +: 4];
        dp_bit    = sh_dp[k];
        blank_bit = sh_blank[k];
        if (cnt >= CW'(GUARD)) begin
          an_nx[k] = 1'b1;
        end
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (nib),
    .segs   (glyph7)
  );

  // Compose the active-high segment byte; a blanked digit also hides its dp.
  always_comb begin
    seg_nx = '0;
    if (!blank_bit) begin
      seg_nx[SEG_A:SEG_G] = glyph7;
      seg_nx[SEG_DP]      = dp_bit;
    end
  end

  // Output registers; seg and scan_idx move on the same edge, inside the anode guard.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_r     <= '0;
      seg_r    <= '0;
      scan_idx <= '0;
    end else begin
      an_r     <= an_nx;
      seg_r    <= seg_nx;
      scan_idx <= idx;
    end
  end

  // Pin polarity applied after the registers.
  always_comb begin
    seg = SEG_ACTIVE_LOW ? ~seg_r : seg_r;
    an  = AN_ACTIVE_LOW  ? ~an_r  : an_r;
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver. Two instances share
// the stimulus: a 4-digit active-low build (DIV=4, GUARD=1) and a 1-digit
// build with uninverted segments (DIV=2, GUARD=1) fed from digit 0.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;

  logic [7:0]  seg_a;
  logic [3:0]  an_a;
  logic [1:0]  idx_a;
  logic [7:0]  seg_b;
  logic        an_b;
  logic        idx_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: edges since the last reset plus the shadow contents.
  int          n = 0;
  logic [15:0] m_dg = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_bl = '1;

  localparam logic [7:0] GLY [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .N_DIGITS(4), .CLK_HZ(16), .SLOT_HZ(4), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_a (
    .clk(clk), .reset(reset), .load(load), .digits(digits), .dp(dp),
    .blank(blank), .seg(seg_a), .an(an_a), .scan_idx(idx_a)
  );

  seg7_scan_driver #(
    .N_DIGITS(1), .CLK_HZ(2), .SLOT_HZ(1), .GUARD(1),
    .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .load(load), .digits(digits[3:0]), .dp(dp[0]),
    .blank(blank[0]), .seg(seg_b), .an(an_b), .scan_idx(idx_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict the pins after the edge, update the model, compare.
  task automatic step(input logic rst, input logic ld, input logic [15:0] dg,
                      input logic [3:0] d, input logic [3:0] b);
    logic [7:0] e_seg_a, e_seg_b, g;
    logic [3:0] e_an_a;
    logic       e_an_b;
    int         e_idx, slot, cnt;
    reset = rst; load = ld; digits = dg; dp = d; blank = b;
    if (rst) begin
      e_seg_a = 8'hFF; e_an_a = 4'hF; e_idx = 0;
      e_seg_b = 8'h00; e_an_b = 1'b1;
    end else begin
      cnt  = n % 4;
      slot = (n / 4) % 4;
      e_an_a = 4'hF;
      if (cnt >= 1) e_an_a[slot] = 1'b0;
      g = GLY[m_dg[slot*4 +: 4]];
      g[0] = m_dp[slot];
      e_seg_a = m_bl[slot] ? 8'hFF : ~g;
      e_idx = slot;
      e_an_b = ((n % 2) >= 1) ? 1'b0 : 1'b1;
      g = GLY[m_dg[3:0]];
      g[0] = m_dp[0];
      e_seg_b = m_bl[0] ? 8'h00 : g;
    end
    if (rst) begin
      n = 0; m_dg = '0; m_dp = '0; m_bl = '1;
    end else begin
      n++;
      if (ld) begin m_dg = dg; m_dp = d; m_bl = b; end
    end
    @(posedge clk);
    #1;
    check("seg_a", 32'(seg_a), 32'(e_seg_a));
    check("an_a",  32'(an_a),  32'(e_an_a));
    check("idx_a", 32'(idx_a), 32'(e_idx));
    check("seg_b", 32'(seg_b), 32'(e_seg_b));
    check("an_b",  32'(an_b),  32'(e_an_b));
    check("idx_b", 32'(idx_b), 32'd0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, $urandom, $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; digits = '0; dp = '0; blank = '0;

    // Reset held 3 cycles, then a dark scan with no load.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, '0);
    idle(12);
    check("dark_seg", 32'(seg_a), 32'hFF);

    // Load 0x3A10 with dp on digit 2, then let it scan.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 16'h3A10, 4'b0100, 4'b0000);
    for (int k = 0; k < 64 && n != 6; k++) step(1'b0, 1'b0, '0, '0, '0);
    check("pre_load_seg", 32'(seg_a), 32'h9F);

    // Mid-slot load during slot 1: digit 1 becomes F, anode stays on digit 1.
    step(1'b0, 1'b1, 16'h3AF0, 4'b0100, 4'b0000);
    check("midslot_old_seg", 32'(seg_a), 32'h9F);
    step(1'b0, 1'b0, '0, '0, '0);
    check("midslot_new_seg", 32'(seg_a), 32'h71);
    check("midslot_an", 32'(an_a), 32'hD);
    idle(18);

    // Blanking digit 3 with 8888 and all dps off.
    step(1'b0, 1'b1, 16'h8888, 4'b0000, 4'b1000);
    idle(20);
    for (int k = 0; k < 64 && (n % 16) != 1; k++) step(1'b0, 1'b0, '0, '0, '0);
    check("blank_lit_seg", 32'(seg_a), 32'h01);

    // Reset during slot 2 together with load: load is discarded.
    for (int k = 0; k < 64 && (n % 16) != 9; k++) step(1'b0, 1'b0, '0, '0, '0);
    step(1'b1, 1'b1, 16'h1234, 4'b1111, 4'b0000);
    step(1'b0, 1'b0, '0, '0, '0);
    check("post_reset_an", 32'(an_a), 32'hF);
    idle(6);
    check("post_reset_seg", 32'(seg_a), 32'hFF);

    // Random traffic: sparse loads and occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
